// File: rtl/reg_file.sv
// RV32I integer register file: x1..x31 storage, x0 reads as zero.
// Two combinational read ports, one synchronous write port, optional write-first bypass.
module reg_file #(
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned ADDR_W      = 5,
    parameter bit          WRITE_FIRST = 1'b0
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              rd_wren_i,
    input  logic [ADDR_W-1:0] rs1_addr_i,
    input  logic [ADDR_W-1:0] rs2_addr_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    input  logic [DATA_W-1:0] rd_data_i,
    output logic [DATA_W-1:0] rs1_data_o,
    output logic [DATA_W-1:0] rs2_data_o
);

    localparam int unsigned NumRegs = 2 ** ADDR_W;

    // x0 has no storage; index 0 is never written or read from this array.
    logic [DATA_W-1:0] regs_q [1:NumRegs-1];

    logic wr_active;
    assign wr_active = rd_wren_i && (rd_addr_i != '0);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int i = 1; i < NumRegs; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_active) begin
            regs_q[rd_addr_i] <= rd_data_i;
        end
    end

    function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] addr);
        logic [DATA_W-1:0] data;
        data = '0;
        // The x0 zero rule is checked first so it also overrides the bypass.
        if (addr != '0) begin
            if (WRITE_FIRST && wr_active && (rd_addr_i == addr)) begin
                data = rd_data_i;
            end else begin
                data = regs_q[addr];
            end
        end
        return data;
    endfunction

    always_comb begin
        rs1_data_o = '0;
        rs2_data_o = '0;
        rs1_data_o = read_port(rs1_addr_i);
        rs2_data_o = read_port(rs2_addr_i);
    end

endmodule

// File: tb/tb_reg_file.sv
// Bench for reg_file: one instance per read-during-write policy sharing all inputs.
// Directed vector table, a held-write sequence, then random traffic against an array model.
module tb_reg_file;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wren;
    logic [4:0]  ra1, ra2, wa;
    logic [31:0] wd;
    logic [31:0] r1_wf0, r2_wf0, r1_wf1, r2_wf1;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    reg_file #(.DATA_W(32), .ADDR_W(5), .WRITE_FIRST(1'b0)) dut_wf0 (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .rd_wren_i  (wren),
        .rs1_addr_i (ra1),
        .rs2_addr_i (ra2),
        .rd_addr_i  (wa),
        .rd_data_i  (wd),
        .rs1_data_o (r1_wf0),
        .rs2_data_o (r2_wf0)
    );

    reg_file #(.DATA_W(32), .ADDR_W(5), .WRITE_FIRST(1'b1)) dut_wf1 (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .rd_wren_i  (wren),
        .rs1_addr_i (ra1),
        .rs2_addr_i (ra2),
        .rd_addr_i  (wa),
        .rd_data_i  (wd),
        .rs1_data_o (r1_wf1),
        .rs2_data_o (r2_wf1)
    );

    typedef struct {
        logic        rst_n;
        logic        wren;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [4:0]  ra1;
        logic [4:0]  ra2;
        logic [31:0] e1_wf0;
        logic [31:0] e2_wf0;
        logic [31:0] e1_wf1;
        logic [31:0] e2_wf1;
    } vec_t;

    vec_t vecs[$];

    // Architectural state: x0 entry kept at zero.
    logic [31:0] mdl [32];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic we, input logic [4:0] a_w,
                         input logic [31:0] d, input logic [4:0] a1, input logic [4:0] a2);
        rst_n = r;
        wren  = we;
        wa    = a_w;
        wd    = d;
        ra1   = a1;
        ra2   = a2;
    endtask

    // Inputs change 1 after a rising edge; outputs are sampled 3 later, clear of both edges.
    task automatic next_edge();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] model_read(input logic [4:0] a, input bit wf);
        if (a == 5'd0) return 32'h0;
        if (wf && rst_n && wren && (wa == a)) return wd;
        return mdl[a];
    endfunction

    function automatic vec_t mk(input logic r, input logic we, input logic [4:0] a_w,
                                input logic [31:0] d, input logic [4:0] a1, input logic [4:0] a2,
                                input logic [31:0] e10, input logic [31:0] e20,
                                input logic [31:0] e11, input logic [31:0] e21);
        vec_t v;
        v.rst_n = r;   v.wren = we;   v.wa = a_w;    v.wd = d;
        v.ra1 = a1;    v.ra2 = a2;
        v.e1_wf0 = e10; v.e2_wf0 = e20; v.e1_wf1 = e11; v.e2_wf1 = e21;
        return v;
    endfunction

    initial begin
        // Expected values are those seen before the rising edge that ends each vector.
        vecs.push_back(mk(0, 0, 0, 0,            0,  0,  0, 0, 0, 0));
        vecs.push_back(mk(1, 1, 7, 32'hDEADBEEF, 7,  31, 0, 0, 32'hDEADBEEF, 0));
        vecs.push_back(mk(0, 1, 9, 32'hCAFEF00D, 7,  31, 32'hDEADBEEF, 0, 32'hDEADBEEF, 0));
        vecs.push_back(mk(0, 0, 0, 0,            7,  9,  0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0,            7,  31, 0, 0, 0, 0));
        vecs.push_back(mk(1, 1, 2, 32'h44444444, 2,  2,  0, 0, 32'h44444444, 32'h44444444));
        vecs.push_back(mk(1, 0, 0, 0,            2,  2,  32'h44444444, 32'h44444444,
                          32'h44444444, 32'h44444444));
        vecs.push_back(mk(1, 1, 1, 32'h12345678, 1,  2,  0, 32'h44444444,
                          32'h12345678, 32'h44444444));
        vecs.push_back(mk(1, 0, 0, 0,            1,  2,  32'h12345678, 32'h44444444,
                          32'h12345678, 32'h44444444));
        vecs.push_back(mk(1, 1, 5, 32'hFFFFFFFF, 5,  5,  0, 0, 32'hFFFFFFFF, 32'hFFFFFFFF));
        vecs.push_back(mk(1, 0, 0, 0,            5,  5,  32'hFFFFFFFF, 32'hFFFFFFFF,
                          32'hFFFFFFFF, 32'hFFFFFFFF));
        vecs.push_back(mk(1, 0, 0, 0,            1,  2,  32'h12345678, 32'h44444444,
                          32'h12345678, 32'h44444444));
        vecs.push_back(mk(1, 1, 0, 32'hA5A5A5A5, 0,  0,  0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 3, 32'hDDDDDDDD, 0,  3,  0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0,            3,  0,  0, 0, 0, 0));
        vecs.push_back(mk(1, 1, 4, 32'h11111111, 4,  3,  0, 0, 32'h11111111, 0));
        vecs.push_back(mk(1, 1, 4, 32'h22222222, 4,  4,  32'h11111111, 32'h11111111,
                          32'h22222222, 32'h22222222));
        vecs.push_back(mk(1, 0, 0, 0,            4,  1,  32'h22222222, 32'h12345678,
                          32'h22222222, 32'h12345678));

        drive(0, 0, 0, 0, 0, 0);
        foreach (vecs[i]) begin
            drive(vecs[i].rst_n, vecs[i].wren, vecs[i].wa, vecs[i].wd, vecs[i].ra1, vecs[i].ra2);
            #2;
            check($sformatf("vec%0d rs1 wf0", i), r1_wf0, vecs[i].e1_wf0);
            check($sformatf("vec%0d rs2 wf0", i), r2_wf0, vecs[i].e2_wf0);
            check($sformatf("vec%0d rs1 wf1", i), r1_wf1, vecs[i].e1_wf1);
            check($sformatf("vec%0d rs2 wf1", i), r2_wf1, vecs[i].e2_wf1);
            next_edge();
        end

        // Write enable held high on x10 with new data every cycle.
        for (int k = 0; k < 4; k++) begin
            drive(1, 1, 10, 32'h0A000000 + 32'(k), 10, 4);
            next_edge();
            drive(1, 0, 10, 32'h0, 10, 4);
            #2;
            check($sformatf("held x10 step%0d", k), r1_wf0, 32'h0A000000 + 32'(k));
            check($sformatf("held x4 step%0d", k), r2_wf1, 32'h22222222);
        end
        next_edge();

        // Random traffic from a fresh reset.
        drive(0, 0, 0, 0, 0, 0);
        next_edge();
        for (int i = 0; i < 32; i++) mdl[i] = 32'h0;
        for (int n = 0; n < 600; n++) begin
            logic [4:0] a_w;
            a_w = 5'($urandom_range(0, 31));
            drive(1, 1'($urandom_range(0, 2) != 0), a_w, $urandom,
                  ($urandom_range(0, 3) == 0) ? a_w : 5'($urandom_range(0, 31)),
                  ($urandom_range(0, 3) == 0) ? a_w : 5'($urandom_range(0, 31)));
            #2;
            check($sformatf("rand%0d rs1 wf0", n), r1_wf0, model_read(ra1, 1'b0));
            check($sformatf("rand%0d rs2 wf0", n), r2_wf0, model_read(ra2, 1'b0));
            check($sformatf("rand%0d rs1 wf1", n), r1_wf1, model_read(ra1, 1'b1));
            check($sformatf("rand%0d rs2 wf1", n), r2_wf1, model_read(ra2, 1'b1));
            if (wren && wa != 5'd0) mdl[wa] = wd;
            next_edge();
        end

        // Final sweep of every register on both ports with writes idle.
        for (int a = 0; a < 32; a++) begin
            drive(1, 0, 0, 0, 5'(a), 5'(31 - a));
            #2;
            check($sformatf("sweep x%0d wf0", a), r1_wf0, mdl[a]);
            check($sformatf("sweep x%0d wf1", 31 - a), r2_wf1, mdl[31 - a]);
            next_edge();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
